// File: rtl/bpsk_pkg.sv
// bpsk_pkg: constants and helpers shared by the BPSK demodulator and
// the matching modulator.
//   midscale()  - offset-binary zero level for a given sample width
//   acc_width() - correlator width that cannot overflow over one symbol
//   BIT_PHASE0 / BIT_PHASE180 - bit polarity per carrier phase
package bpsk_pkg;

  localparam logic BIT_PHASE0   = 1'b1;
  localparam logic BIT_PHASE180 = 1'b0;

  function automatic int midscale(input int bits);
    return 1 << (bits - 1);
  endfunction

  // Product of two signed (bits+1) values needs 2*bits+2 bits; summing
  // samples*cycles of them adds log2 of that count.
  function automatic int acc_width(input int bits, input int samples, input int cycles);
    return 2 * bits + 2 + $clog2(samples * cycles);
  endfunction

endpackage

// File: rtl/sine_lut.sv
// sine_lut: combinational carrier reference shared with the transmit path.
// One carrier period spans SAMPLES phase steps; each half period is a
// parabolic approximation of a sine lobe, offset binary around midscale.
// Ports:
//   in  - phase index, log2(SAMPLES) bits
//   out - reference amplitude, BITS bits, offset binary
module sine_lut
  import bpsk_pkg::*;
#(
  parameter int SAMPLES = 512,
  parameter int BITS    = 12
) (
  input  logic [$clog2(SAMPLES)-1:0] in,
  output logic [BITS-1:0]            out
);

  localparam int PW   = $clog2(SAMPLES);
  localparam int HALF = SAMPLES / 2;
  localparam int MW   = 2 * PW + BITS + 2;
  // 4*peak, so that u*(HALF-u) at u=HALF/2 maps exactly to the peak
  localparam logic [MW-1:0] PEAK4 = MW'(4 * (midscale(BITS) - 1));

  logic [MW-1:0]   u;
  logic [MW-1:0]   v;
  logic [MW-1:0]   amp_full;
  logic [BITS-1:0] amp;
  logic [BITS-1:0] mid;

  always_comb begin
    u        = MW'(in[PW-2:0]);
    v        = u * (MW'(HALF) - u);
    amp_full = (v * PEAK4) >> (2 * (PW - 1));
    amp      = BITS'(amp_full);
    mid      = BITS'(midscale(BITS));
    out      = in[PW-1] ? (mid - amp) : (mid + amp);
  end

endmodule

// File: rtl/bpsk_demod.sv
// bpsk_demod: coherent BPSK integrate-and-dump receiver.
// Each accepted ADC sample is correlated against the local sine_lut
// reference; products are summed over CYCLES_PER_SYMBOL carrier periods
// and one hard decision plus the signed correlation is emitted per symbol.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   sample_valid  - one sample accepted per cycle when high
//   sample        - ADC sample, offset binary
//   sync          - restarts symbol/phase alignment, drops the partial symbol
//   bit_valid     - one-cycle pulse per decided symbol
//   bit_out       - decision (1 = carrier phase 0)
//   corr          - signed correlation of the completed symbol
module bpsk_demod
  import bpsk_pkg::*;
#(
  parameter int SAMPLES           = 512,
  parameter int BITS              = 12,
  parameter int CYCLES_PER_SYMBOL = 4,
  parameter int ACC_W             = acc_width(BITS, SAMPLES, CYCLES_PER_SYMBOL)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [BITS-1:0]         sample,
  input  logic                    sync,
  output logic                    bit_valid,
  output logic                    bit_out,
  output logic signed [ACC_W-1:0] corr
);

  localparam int PW  = $clog2(SAMPLES);
  localparam int CW  = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
  localparam int SW  = BITS + 1;
  localparam int PRW = 2 * BITS + 2;
  localparam logic [PW-1:0]        PHASE_MAX  = PW'(SAMPLES - 1);
  localparam logic [CW-1:0]        PERIOD_MAX = CW'(CYCLES_PER_SYMBOL - 1);
  localparam logic signed [SW-1:0] MID_S      = SW'(midscale(BITS));

  logic [PW-1:0]           phase;
  logic [PW-1:0]           phase_eff;
  logic [CW-1:0]           period;
  logic [CW-1:0]           period_eff;
  logic                    last_eff;
  logic [BITS-1:0]         lut;

  logic                    a_valid;
  logic                    a_last;
  logic signed [SW-1:0]    a_s;
  logic signed [SW-1:0]    a_r;
  logic                    b_valid;
  logic                    b_last;
  logic signed [PRW-1:0]   b_p;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;

  // A sample arriving together with sync is the first of the new symbol,
  // so the counters it sees (and the LUT address) are forced to zero.
  always_comb begin
    phase_eff  = sync ? '0 : phase;
    period_eff = sync ? '0 : period;
    last_eff   = (phase_eff == PHASE_MAX) && (period_eff == PERIOD_MAX);
    acc_sum    = acc + ACC_W'(b_p);
  end

  sine_lut #(
    .SAMPLES (SAMPLES),
    .BITS    (BITS)
  ) u_lut (
    .in  (phase_eff),
    .out (lut)
  );

  // Phase/period counters and stage A
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      period  <= '0;
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      a_s     <= '0;
      a_r     <= '0;
    end else begin
      a_valid <= sample_valid;
      a_last  <= sample_valid & last_eff;
      a_s     <= $signed({1'b0, sample}) - MID_S;
      a_r     <= $signed({1'b0, lut}) - MID_S;
      if (sample_valid) begin
        phase <= phase_eff + PW'(1);
        if (phase_eff == PHASE_MAX)
          period <= (period_eff == PERIOD_MAX) ? '0 : period_eff + CW'(1);
        else
          period <= period_eff;
      end else if (sync) begin
        phase  <= '0;
        period <= '0;
      end
    end
  end

  // Stage B: product. sync kills whatever is in A, including a last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_last  <= 1'b0;
      b_p     <= '0;
    end else begin
      b_valid <= a_valid & ~sync;
      b_last  <= a_last;
      b_p     <= PRW'(a_s) * PRW'(a_r);
    end
  end

  // Integrate and dump. The dump clears acc on the same edge that consumes
  // the last product, so the next symbol's first product adds to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      corr      <= '0;
    end else begin
      bit_valid <= 1'b0;
      if (sync) begin
        acc <= '0;
      end else if (b_valid) begin
        if (b_last) begin
          corr      <= acc_sum;
          bit_out   <= acc_sum[ACC_W-1] ? BIT_PHASE180 : BIT_PHASE0;
          bit_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: doc/bpsk_demod.md
Name: bpsk_demod

Overview:
- Coherent BPSK receiver front end. It is the counterpart of the transmit path, which indexes sine_lut with a phase counter to synthesize the carrier.
- Takes offset-binary ADC samples and correlates each one against the local sine_lut reference. It integrates over one symbol (integrate-and-dump) and emits one hard bit plus the signed correlation per symbol.
- Sits between the ADC sample interface and the bit/frame recovery logic.

Parameters:
- SAMPLES, 512, samples per carrier period; sine_lut depth; power of two.
- BITS, 12, sample and LUT amplitude width, offset binary.
- CYCLES_PER_SYMBOL, 4, carrier periods per BPSK symbol; power of two.
- ACC_W, 2*BITS+2+$clog2(SAMPLES*CYCLES_PER_SYMBOL) (=37), accumulator and corr width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  sample qualifier; one sample accepted per cycle when high.
- sample  in  BITS  ADC sample, offset binary, midscale 2**(BITS-1).
- sync  in  1  symbol/phase alignment strobe from acquisition logic.
- bit_valid  out  1  one-cycle pulse, new decision available.
- bit_out  out  1  decided bit; 1 = carrier phase 0, 0 = phase 180°.
- corr  out  ACC_W  signed correlation of the completed symbol.

Behaviour:
- Reset (sync, active-high): phase counter, period counter, accumulator, pipeline valids, bit_valid, bit_out and corr all go to 0. Reset asserted mid-symbol discards the partial symbol; no bit_valid is emitted for it.
- Phase counter:
  - log2(SAMPLES) bits; drives sine_lut.in combinationally.
  - Increments on each accepted sample; wraps SAMPLES-1 -> 0.
  - On wrap, the period counter increments; it wraps CYCLES_PER_SYMBOL-1 -> 0.
  - Last sample of a symbol = phase SAMPLES-1 and period CYCLES_PER_SYMBOL-1.
- sample_valid low: counters hold; a bubble propagates through the pipeline; the accumulator is unchanged by the bubble.
- Pipeline (accepted sample at cycle t):
  - Stage A, edge ending t: registers s = sample - 2**(BITS-1) and r = lut - 2**(BITS-1), both signed BITS+1, plus the valid and last flags.
  - Stage B, edge ending t+1: registers p = s*r, signed 2*BITS+2.
  - Edge ending t+2, if B is valid and not last: acc <= acc + sign_extend(p).
  - Edge ending t+2, if B is valid and last: corr <= acc + p; bit_out <= (acc + p >= 0); bit_valid <= 1; acc <= 0.
  - Decision latency: bit_valid is high during cycle t+3, where t is the cycle the last sample was accepted. It is high for exactly one cycle.
- Zero correlation decides bit_out = 1.
- bit_out and corr hold their values until the next decision.
- No overflow: ACC_W covers the worst-case magnitude 2**(2*BITS) * SAMPLES * CYCLES_PER_SYMBOL.
- Back-to-back symbols: the dump edge clears acc, and the first product of the next symbol arrives one edge later. No collision and no lost product.
- sync high:
  - Counters go to 0.
  - acc and Stage A/B valids are cleared.
  - No bit_valid is produced for the partial symbol, including one whose last sample is already in flight in the pipeline.
- sync and sample_valid high in the same cycle: the sample is accepted as phase 0, period 0 of the new symbol.
- sync and rst both high: rst dominates; the result is identical to rst alone.

Decomposition:
- Package bpsk_pkg holds:
  - midscale constant function (2**(BITS-1));
  - acc width function;
  - the bit-polarity convention constants shared with the modulator (BIT_PHASE0 = 1).
- One sub-module: the existing sine_lut (SAMPLES, BITS), instantiated for the reference.
- The NCO/counter and the MAC stay inline.

Test Plan:
- Reset: rst high 3 cycles with sample_valid toggling -> bit_valid, bit_out and corr are 0; the first symbol after rst is decoded from sample 0.
- In-phase loopback: 2048 contiguous samples equal to sine_lut(phase) -> a single bit_valid on cycle t_last+3, bit_out = 1, corr = exact sum of (lut-2048)^2 from the bench model (positive).
- Inverted carrier: sample = 4096 - lut (clamped to 4095) -> bit_out = 0, corr negative, equal to the model value.
- DC midscale: 2048 samples of 2048 -> corr = 0, bit_out = 1.
- Gapped input: sample_valid on every other cycle with the in-phase data -> same corr as the in-phase case; bit_valid 3 cycles after the last accepted sample.
- sync mid-symbol and at symbol end:
  - sync after 1000 samples -> no bit_valid for that symbol; the next 2048 samples decode correctly.
  - sync on the cycle after the last sample -> that symbol's bit_valid is suppressed.
